mini_alu: RTL

MINI_ALU -- requirements
Module: mini_alu

---
 rtl/tinyalu_pkg.sv | 29 ++
 rtl/mini_alu_mul.sv | 40 ++++
 rtl/mini_alu.sv | 115 +++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the mini ALU: operation codes, FSM states and the multiply latency default.
// Also used by the testbench so both sides agree on the op encoding.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        HOLD
    } state_t;

    localparam int unsigned MUL_LATENCY_DEFAULT = 3;
    localparam int unsigned CNT_W               = 3;

    // Codes 101 and 110 have no operation assigned
    function automatic logic is_illegal(input logic [2:0] code);
        return (code == 3'b101) || (code == 3'b110);
    endfunction

endpackage

// File: rtl/mini_alu_mul.sv
// Registered unsigned 8x8 multiplier pipeline with valid tracking and async active-low reset.
module mini_alu_mul
    import tinyalu_pkg::*;
#(
    parameter int unsigned DEPTH = MUL_LATENCY_DEFAULT - 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        valid_out,
    output logic [15:0] product
);

    logic [15:0]      prod_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_in;
            if (valid_in) begin
                prod_q[0] <= 16'(a) * 16'(b);
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[DEPTH-1];
    assign product   = prod_q[DEPTH-1];

endmodule

// File: rtl/mini_alu.sv
// Small multi-cycle ALU with start/done handshake; add/and/xor in one cycle, mul in MUL_LATENCY.
// Define MINI_ALU_ILLEGAL_OP_EN to add the err port flagging op codes 101/110.
module mini_alu
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
`ifdef MINI_ALU_ILLEGAL_OP_EN
    ,
    output logic        err
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mul_start;
    logic             mul_valid;
    logic [15:0]      mul_product;

    assign mul_start = (state == IDLE) && start && (op == mul_op);

    // The result register in this FSM is the last of the MUL_LATENCY stages
    mini_alu_mul #(
        .DEPTH(MUL_LATENCY - 1)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (mul_start),
        .a        (A),
        .b        (B),
        .valid_out(mul_valid),
        .product  (mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
`ifdef MINI_ALU_ILLEGAL_OP_EN
            err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (op)
                            add_op: begin
                                result <= 16'(A) + 16'(B);
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            and_op: begin
                                result <= {8'h00, A & B};
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            xor_op: begin
                                result <= {8'h00, A ^ B};
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                            mul_op: begin
                                cnt   <= CNT_W'(MUL_LATENCY - 2);
                                state <= BUSY;
                            end
`ifdef MINI_ALU_ILLEGAL_OP_EN
                            3'b101, 3'b110: begin
                                result <= '0;
                                done   <= 1'b1;
                                err    <= is_illegal(op);
                                state  <= DONE;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if ((cnt == '0) && mul_valid) begin
                        result <= mul_product;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
`ifdef MINI_ALU_ILLEGAL_OP_EN
                    err   <= 1'b0;
`endif
                    state <= HOLD;
                end
                HOLD: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
